// File: rtl/coin_credit_accumulator.sv
// coin_credit_accumulator
//   Adds inserted coins to a running credit in cents. A purchase is settled
//   against a price, or the credit is refunded on cancel. The resulting
//   change amount goes to the change dispenser over a valid/ack handshake.
//
//   Configuration macro: COIN_CANCEL_EN
//     defined   - cancel refunds the whole credit and takes priority over vend_req
//     undefined - cancel is ignored; credit leaves only through a vend or reset
//
//   Parameters:
//     MAX_CREDIT  largest credit in cents; a coin that would exceed it is rejected
//     CW          width of the credit, price and change values
//                 (MAX_CREDIT + 25 must fit in CW bits)
//
//   Ports:
//     clk, rst        clock (rising edge) and asynchronous active-high reset
//     coin_valid      one-cycle strobe; a coin is present on coin_type
//     coin_type       00 penny, 01 nickel, 10 dime, 11 quarter
//     price           item price, sampled in the vend_req cycle
//     vend_req        one-cycle purchase request
//     cancel          one-cycle refund request
//     change_ack      dispenser has taken change
//     credit          current credit (registered)
//     change          amount to dispense, valid while change_valid is high
//     change_valid    change handshake valid
//     vend_ok         one-cycle pulse: purchase accepted
//     coin_reject     one-cycle pulse: coin returned and not credited

module coin_credit_accumulator #(
  parameter int unsigned MAX_CREDIT = 1000,
  parameter int unsigned CW         = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          coin_valid,
  input  logic [1:0]    coin_type,
  input  logic [CW-1:0] price,
  input  logic          vend_req,
  input  logic          cancel,
  input  logic          change_ack,
  output logic [CW-1:0] credit,
  output logic [CW-1:0] change,
  output logic          change_valid,
  output logic          vend_ok,
  output logic          coin_reject
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SETTLE  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] coin_value;
  logic [CW-1:0] coin_sum;
  logic          coin_fits;
  logic          vend_go;
  logic          cancel_go;

  // Coin code to cents
  always_comb begin
    coin_value = '0;
    case (coin_type)
      2'b00:   coin_value = CW'(1);
      2'b01:   coin_value = CW'(5);
      2'b10:   coin_value = CW'(10);
      default: coin_value = CW'(25);
    endcase
  end

  // Sum cannot wrap because MAX_CREDIT + 25 fits in CW bits
  assign coin_sum  = credit + coin_value;
  assign coin_fits = (coin_sum <= CW'(MAX_CREDIT));
  assign vend_go   = vend_req && (credit >= price);

`ifdef COIN_CANCEL_EN
  assign cancel_go = cancel;
`else
  // Port kept for a uniform pinout; refunds are disabled in this build
  logic unused_cancel;
  assign unused_cancel = cancel;
  assign cancel_go     = 1'b0;
`endif

  // Credit / settle state machine with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      credit       <= '0;
      change       <= '0;
      change_valid <= 1'b0;
      vend_ok      <= 1'b0;
      coin_reject  <= 1'b0;
    end else begin
      vend_ok     <= 1'b0;
      coin_reject <= 1'b0;
      case (state)
        IDLE, COLLECT: begin
          if (cancel_go) begin
            // Refund wins over a simultaneous vend; a coin in the same cycle is returned
            change       <= credit;
            change_valid <= 1'b1;
            credit       <= '0;
            coin_reject  <= coin_valid;
            state        <= SETTLE;
          end else if (vend_go) begin
            change       <= credit - price;
            change_valid <= 1'b1;
            vend_ok      <= 1'b1;
            credit       <= '0;
            coin_reject  <= coin_valid;
            state        <= SETTLE;
          end else if (coin_valid) begin
            // A short vend_req falls through here and the coin is handled normally
            if (coin_fits) begin
              credit <= coin_sum;
              state  <= COLLECT;
            end else begin
              coin_reject <= 1'b1;
            end
          end
        end
        SETTLE: begin
          coin_reject <= coin_valid;
          if (change_ack) begin
            // change keeps its last value after the handshake closes
            change_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          credit       <= '0;
          change_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
